imem_loader: RTL
================

Name: imem_loader

Overview:
Writer side of the instruction-memory debug write port on inst_fetch. Accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit words, and issues one-cycle word writes at consecutive addresses starting from BASE_ADDR. Holds the core in reset during the load, then releases it so fetch restarts at PC 0 on the new image.

Parameters:
DATA_WIDTH, 32, instruction word / address width; matches REG_RANGE.
MEM_BYTES, 2048, instruction memory size in bytes; must be a multiple of 4.
BASE_ADDR, 0, byte address of the first word written.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-low reset (asserted at 0).
start  in  1  single-cycle request to begin a load session; ignored unless busy=0.
byte_valid  in  1  byte_data/byte_last are valid.
byte_data  in  8  stream byte.
byte_last  in  1  marks the final byte of the image.
byte_ready  out  1  loader accepts a byte this cycle.
write_en  out  1  one-cycle write strobe to imem.
write_addr  out  DATA_WIDTH  byte address of the write, word-aligned.
write_data  out  DATA_WIDTH  word to write.
core_hold  out  1  drives core reset/pc_sel; 1 = core held.
busy  out  1  session in progress.
done  out  1  one-cycle pulse at end of session.
overflow  out  1  sticky; image exceeded memory. Cleared on next start.
word_count  out  clog2(MEM_BYTES/4)+1  words written this session.

Behaviour:
- Reset (reset=0, async): byte_ready=0, write_en=0, write_addr=BASE_ADDR, write_data=0, core_hold=0, busy=0, done=0, overflow=0, word_count=0, state=IDLE, byte lane index=0.
- Handshake: a byte transfers on a rising edge with byte_valid=1 and byte_ready=1. byte_ready is a registered state decode and does not depend on byte_valid.
- IDLE: byte_ready=0. On start=1 the next state is COLLECT. Also: write_addr=BASE_ADDR, word_count=0, overflow=0, lane=0, assembly register cleared, core_hold=1, busy=1.
- COLLECT: byte_ready=1.
  - Each accepted byte goes into lane `lane`, bits [8*lane+7:8*lane], and lane increments.
  - If lane==3 or byte_last=1 on acceptance, go to WRITE.
  - On a byte_last partial word, the unfilled upper lanes are 0.
- WRITE (exactly 1 cycle): byte_ready=0, write_en=1, write_data=assembled word, write_addr=current address.
  - Next cycle: address += 4, word_count += 1, lane=0, assembly register cleared.
  - If byte_last was seen, go to RELEASE; otherwise go to COLLECT.
- Full memory: if word_count == MEM_BYTES/4 while in COLLECT:
  - Accepted bytes are discarded and overflow is set to 1.
  - byte_ready stays 1 so the source drains.
  - byte_last goes to RELEASE. No write is issued at any address >= BASE_ADDR+MEM_BYTES.
- RELEASE (1 cycle): done=1, core_hold=1. Next state is IDLE with core_hold=0, busy=0. The core leaves reset on the cycle after the done pulse.
- Latency: 4th byte accepted at edge N gives write_en high during cycle N+1. Peak throughput is 4 bytes per 5 cycles.
- start while busy=1: ignored, no state change.
- byte_valid while not in COLLECT: not accepted, since byte_ready=0. The source must hold the byte.
- Empty session: byte_last can only arrive with a byte, so an empty session is not possible. A lone last byte produces a single zero-padded word.
- Reset mid-session: outputs return to reset values immediately and core_hold drops. Memory contents already written are left as is, and the next start reloads from BASE_ADDR.

Test Plan:
1. Assert reset=0 mid-idle, release -> all outputs 0, write_addr=BASE_ADDR=0, byte_ready=0.
2. Load two words. Sequence: start pulse, then bytes 13 00 00 00 93 00 10 00 with byte_last on the 8th, valid every cycle. Required response:
   - write_en two times, addr 0x0/data 0x00000013 and addr 0x4/data 0x00100093.
   - done pulse one cycle after the second write; word_count=2.
   - core_hold=1 from the cycle after start until the cycle after done.
3. Partial word: send 6 bytes AA BB CC DD EE FF, last on FF -> writes addr 0 data 0xDDCCBBAA, addr 4 data 0x0000FFEE.
4. Back-pressure and gaps: send the same stream as test 2 with byte_valid toggling randomly -> identical write sequence, no duplicated or dropped bytes, byte_ready=0 during WRITE cycles.
5. Overflow with MEM_BYTES=16: send 20 bytes, last on the 20th -> exactly 4 writes (addr 0,4,8,C), overflow=1, word_count=4, done pulses. A later start clears overflow.
6. Reset and restart. Sequence:
   - During a session, issue a second start after 5 bytes -> the second start is ignored.
   - After 2 writes, assert reset -> immediate reset values.
   - New start -> first write at addr 0.

Source files
------------

// File: rtl/imem_loader.sv
// Byte-stream loader for the instruction-memory debug write port: assembles
// little-endian words, writes them from BASE_ADDR upward and holds the core in reset meanwhile.
module imem_loader #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    MEM_BYTES  = 2048,
    parameter logic [DATA_WIDTH-1:0] BASE_ADDR  = '0,
    localparam int                   WC_W       = $clog2(MEM_BYTES / 4) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    input  logic                  byte_last,
    output logic                  byte_ready,
    output logic                  write_en,
    output logic [DATA_WIDTH-1:0] write_addr,
    output logic [DATA_WIDTH-1:0] write_data,
    output logic                  core_hold,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [WC_W-1:0]       word_count
);

    localparam logic [WC_W-1:0] MEM_WORDS = WC_W'(MEM_BYTES / 4);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_WRITE,
        S_RELEASE
    } state_t;

    state_t                r_state;
    logic [1:0]            r_lane;
    logic [DATA_WIDTH-1:0] r_asm;
    logic                  r_last;
    logic                  r_byte_ready;
    logic                  r_write_en;
    logic [DATA_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_hold;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_ovf;
    logic [WC_W-1:0]       r_wc;

    logic                  w_accept;
    logic                  w_full;
    logic [DATA_WIDTH-1:0] w_word;

    assign w_accept = byte_valid & r_byte_ready;
    assign w_full   = (r_wc == MEM_WORDS);
    // Unfilled upper lanes stay zero because the assembly register is cleared per word.
    assign w_word   = r_asm | (DATA_WIDTH'(byte_data) << {r_lane, 3'b000});

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_lane       <= 2'd0;
            r_asm        <= '0;
            r_last       <= 1'b0;
            r_byte_ready <= 1'b0;
            r_write_en   <= 1'b0;
            r_addr       <= BASE_ADDR;
            r_wdata      <= '0;
            r_hold       <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_ovf        <= 1'b0;
            r_wc         <= '0;
        end else begin
            r_done     <= 1'b0;
            r_write_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state      <= S_COLLECT;
                        r_byte_ready <= 1'b1;
                        r_addr       <= BASE_ADDR;
                        r_wc         <= '0;
                        r_ovf        <= 1'b0;
                        r_lane       <= 2'd0;
                        r_asm        <= '0;
                        r_last       <= 1'b0;
                        r_hold       <= 1'b1;
                        r_busy       <= 1'b1;
                    end
                end
                S_COLLECT: begin
                    if (w_accept) begin
                        if (w_full) begin
                            // Memory is full: keep draining the source but drop the bytes.
                            r_ovf <= 1'b1;
                            if (byte_last) begin
                                r_state      <= S_RELEASE;
                                r_byte_ready <= 1'b0;
                                r_done       <= 1'b1;
                            end
                        end else begin
                            r_asm  <= w_word;
                            r_lane <= r_lane + 2'd1;
                            r_last <= byte_last;
                            if (r_lane == 2'd3 || byte_last) begin
                                r_state      <= S_WRITE;
                                r_byte_ready <= 1'b0;
                                r_write_en   <= 1'b1;
                                r_wdata      <= w_word;
                            end
                        end
                    end
                end
                S_WRITE: begin
                    r_addr <= r_addr + DATA_WIDTH'(4);
                    r_wc   <= r_wc + WC_W'(1);
                    r_lane <= 2'd0;
                    r_asm  <= '0;
                    if (r_last) begin
                        r_state <= S_RELEASE;
                        r_done  <= 1'b1;
                    end else begin
                        r_state      <= S_COLLECT;
                        r_byte_ready <= 1'b1;
                    end
                end
                S_RELEASE: begin
                    r_state <= S_IDLE;
                    r_hold  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign byte_ready = r_byte_ready;
    assign write_en   = r_write_en;
    assign write_addr = r_addr;
    assign write_data = r_wdata;
    assign core_hold  = r_hold;
    assign busy       = r_busy;
    assign done       = r_done;
    assign overflow   = r_ovf;
    assign word_count = r_wc;

endmodule
